// File: rtl/led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer
//
// Controller for the 8-LED pattern shift engine. Conditions the four board
// switches (2-FF synchronizer + per-bit debouncer), then runs a small FSM
// (INIT, LOAD, RUN, PAUSE). The FSM produces the engine's MODE select, a
// one-cycle step tick and an engine restart pulse. Every mode change passes
// through a one-cycle LOAD, so the engine is always restarted with a MODE
// that is already stable. Modes change either manually from the switches or
// automatically, rotating after DWELL engine steps.
//
// Parameters
//   PRESCALE : clk cycles per engine step (>= 2)
//   DWELL    : engine steps spent in each mode when auto-rotating (>= 1)
//   DB_LEN   : consecutive cycles a synchronized switch value must differ
//              from the debounced value before it is accepted (>= 1)
//
// Ports
//   clk      : system clock, all state on the rising edge
//   reset    : asynchronous, active-low reset
//   sw[3:0]  : raw switches; [1:0] manual mode, [2] auto enable, [3] pause
//   mode     : MODE select to the pattern engine
//   eng_ce   : one-cycle engine step tick (clock enable)
//   eng_rst  : active-high engine restart, high during INIT and LOAD
//   busy     : high during INIT and LOAD
//   step_cnt : (only with STEP_CNT_EN) saturating count of eng_ce pulses
//
// Build option
//   STEP_CNT_EN : when defined, adds the step_cnt[15:0] output and its
//                 counter. When undefined the port and counter are absent.
//
// Timing notes
//   - A raw switch change shows up on the debounced value 2+DB_LEN cycles
//     later; a bounce restarts the debounce count.
//   - The FSM decides its next state from the debounced value that will be
//     current in that next cycle (db_nxt). State, counters and outputs of a
//     given cycle therefore always agree with that cycle's debounced inputs,
//     and every output is still driven straight from a flop.
//   - In RUN the prescaler counts 0..PRESCALE-1; eng_ce is high in the cycle
//     the count sits at PRESCALE-1, so the first tick comes PRESCALE cycles
//     after LOAD.
// -----------------------------------------------------------------------------
module led_pattern_sequencer #(
  parameter int PRESCALE = 4,
  parameter int DWELL    = 16,
  parameter int DB_LEN   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  sw,
  output logic [1:0]  mode,
  output logic        eng_ce,
  output logic        eng_rst,
  output logic        busy
`ifdef STEP_CNT_EN
  ,
  output logic [15:0] step_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------------
  localparam int PW = $clog2(PRESCALE);     // prescaler 0..PRESCALE-1
  localparam int DW = $clog2(DWELL + 1);    // dwell 0..DWELL
  localparam int CW = $clog2(DB_LEN + 1);   // debounce count 0..DB_LEN-1

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRESC_PRE  = PW'(PRESCALE - 2);
  localparam logic [DW-1:0] DWELL_MAX  = DW'(DWELL);
  localparam logic [CW-1:0] DB_LAST    = CW'(DB_LEN - 1);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_PAUSE = 2'd3;

  // ---------------------------------------------------------------------------
  // Switch synchronizer
  // ---------------------------------------------------------------------------
  logic [3:0] sync_meta;
  logic [3:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= sw;
      sync_q    <= sync_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncer: a bit flips only after the synchronized value has differed
  // from it for DB_LEN consecutive cycles. A cycle where they agree clears
  // the count, so a bounce restarts it.
  // ---------------------------------------------------------------------------
  logic [3:0]         db_q;
  logic [3:0]         db_nxt;
  logic [3:0][CW-1:0] db_cnt_q;
  logic [3:0][CW-1:0] db_cnt_nxt;

  // NOTE: every signal driven here gets a default first, so each path assigns
  // it and no latch is inferred.
  always_comb begin
    db_nxt     = db_q;
    db_cnt_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_nxt[i] = sync_q[i];
        end else begin
          db_cnt_nxt[i] = db_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_q     <= '0;
      db_cnt_q <= '0;
    end else begin
      db_q     <= db_nxt;
      db_cnt_q <= db_cnt_nxt;
    end
  end

  // Debounced controls as they will be in the next cycle.
  logic       pause_n;
  logic       auto_n;
  logic       auto_rise;
  logic [1:0] man_n;

  assign pause_n   = db_nxt[3];
  assign auto_n    = db_nxt[2];
  assign man_n     = db_nxt[1:0];
  assign auto_rise = db_nxt[2] & ~db_q[2];

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  logic [1:0]    state_q;
  logic [1:0]    state_nxt;
  logic [1:0]    mode_q;
  logic [1:0]    mode_nxt;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_nxt;
  logic [PW-1:0] presc_adv;
  logic [DW-1:0] dwell_q;
  logic [DW-1:0] dwell_nxt;
  logic [DW-1:0] dwell_base;
  logic          tick_due;
  logic          tick;
  logic          eng_ce_q;
  logic          eng_rst_q;
  logic          busy_q;

  // Prescaler advance, plus whether that advance lands on PRESCALE-1, which
  // makes the next cycle a step tick.
  assign presc_adv  = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
  assign tick_due   = (presc_q == PRESC_PRE);
  // A debounced auto-enable rising edge restarts the dwell count.
  assign dwell_base = auto_rise ? '0 : dwell_q;

  always_comb begin
    state_nxt = state_q;
    mode_nxt  = mode_q;
    presc_nxt = presc_q;
    dwell_nxt = dwell_q;
    tick      = 1'b0;
    case (state_q)
      ST_INIT: begin
        state_nxt = ST_LOAD;
        mode_nxt  = 2'd0;
      end
      ST_LOAD: begin
        state_nxt = pause_n ? ST_PAUSE : ST_RUN;
        presc_nxt = '0;
        dwell_nxt = '0;
      end
      ST_RUN: begin
        if (pause_n) begin
          // Pause wins over everything; counters freeze, a due tick is dropped.
          state_nxt = ST_PAUSE;
        end else if (auto_n) begin
          // dwell_q reaches DWELL in the cycle carrying the last tick of the
          // mode, so the restart follows that tick by one cycle and eng_ce
          // never coincides with eng_rst.
          if (!auto_rise && (dwell_q >= DWELL_MAX)) begin
            state_nxt = ST_LOAD;
            mode_nxt  = mode_q + 2'd1;
          end else begin
            presc_nxt = presc_adv;
            tick      = tick_due;
            dwell_nxt = dwell_base + (tick_due ? DW'(1) : DW'(0));
          end
        end else if (man_n != mode_q) begin
          state_nxt = ST_LOAD;
          mode_nxt  = man_n;
        end else begin
          presc_nxt = presc_adv;
          tick      = tick_due;
        end
      end
      ST_PAUSE: begin
        // Counts stay frozen; any manual change is picked up from RUN.
        if (!pause_n) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_INIT;
      mode_q    <= 2'd0;
      presc_q   <= '0;
      dwell_q   <= '0;
      eng_ce_q  <= 1'b0;
      eng_rst_q <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_nxt;
      mode_q    <= mode_nxt;
      presc_q   <= presc_nxt;
      dwell_q   <= dwell_nxt;
      eng_ce_q  <= tick;
      eng_rst_q <= (state_nxt == ST_INIT) || (state_nxt == ST_LOAD);
      busy_q    <= (state_nxt == ST_INIT) || (state_nxt == ST_LOAD);
    end
  end

  assign mode    = mode_q;
  assign eng_ce  = eng_ce_q;
  assign eng_rst = eng_rst_q;
  assign busy    = busy_q;

`ifdef STEP_CNT_EN
  // ---------------------------------------------------------------------------
  // Step counter: counts every eng_ce pulse since reset, sticks at all-ones.
  // ---------------------------------------------------------------------------
  logic [15:0] step_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_cnt_q <= '0;
    end else if (eng_ce_q && (step_cnt_q != 16'hFFFF)) begin
      step_cnt_q <= step_cnt_q + 16'd1;
    end
  end

  assign step_cnt = step_cnt_q;
`endif

endmodule
